// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access widths, FSM states and the
// default timeout used when LSU_TIMEOUT_EN is defined.
package lsu_pkg;

    localparam logic [1:0] WHB_BYTE = 2'b00;
    localparam logic [1:0] WHB_HALF = 2'b01;
    localparam logic [1:0] WHB_WORD = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // whb=11 is never a legal width, so it is reported like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] whb, input logic [1:0] offs);
        case (whb)
            WHB_BYTE: is_misaligned = 1'b0;
            WHB_HALF: is_misaligned = offs[0];
            WHB_WORD: is_misaligned = |offs;
            default:  is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offs,
    input  logic [1:0]  i_whb,
    input  logic        i_su,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offs)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offs[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_whb)
            WHB_BYTE: o_data = {{24{i_su & w_byte[7]}}, w_byte};
            WHB_HALF: o_data = {{16{i_su & w_half[15]}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one request at a time to a word-wide data memory with byte
// enables. Optional REQ/WAIT timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned AW = 32
`ifdef LSU_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_rw,
    input  logic [1:0]    i_whb,
    input  logic          i_su,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_rsp_valid,
    output logic          o_rsp_err,
    output logic [31:0]   o_rsp_rdata,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [3:0]    o_mem_be,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [31:0]   i_mem_rdata
);

    lsu_state_e    r_state;
    lsu_state_e    w_state_nxt;

    logic          r_rw;
    logic [1:0]    r_whb;
    logic          r_su;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [31:0]   r_rdata;

    logic          w_accept;
    logic          w_timeout;
    logic          w_timeout_fire;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load_data;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Counter runs across REQ and WAIT together; it is held at zero in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_timeout = (r_state == ST_REQ || r_state == ST_WAIT) && (r_cnt == LAST_CNT);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_timeout_fire = w_timeout
                          && !((r_state == ST_REQ)  && i_mem_gnt)
                          && !((r_state == ST_WAIT) && i_mem_rvalid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = is_misaligned(i_whb, i_addr[1:0]) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_mem_gnt) begin
                    w_state_nxt = r_rw ? ST_WAIT : ST_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (i_mem_rvalid || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rw    <= 1'b0;
            r_whb   <= '0;
            r_su    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_rw    <= i_rw;
                r_whb   <= i_whb;
                r_su    <= i_su;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_err   <= is_misaligned(i_whb, i_addr[1:0]);
                r_rdata <= '0;
            end
            if (r_state == ST_WAIT && i_mem_rvalid) begin
                r_rdata <= w_load_data;
            end
            if (w_timeout_fire) begin
                r_err <= 1'b1;
            end
        end
    end

    lsu_load_align u_load_align (
        .i_rdata (i_mem_rdata),
        .i_offs  (r_addr[1:0]),
        .i_whb   (r_whb),
        .i_su    (r_su),
        .o_data  (w_load_data)
    );

    always_comb begin
        w_be    = '0;
        w_wdata = r_wdata;
        case (r_whb)
            WHB_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            WHB_HALF: begin
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
            end
            WHB_WORD: w_be = 4'b1111;
            default:  ;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = '0;
        case (r_state)
            ST_IDLE: o_req_ready = 1'b1;
            ST_REQ: begin
                o_mem_req   = 1'b1;
                o_mem_we    = ~r_rw;
                o_mem_be    = w_be;
                o_mem_addr  = {r_addr[AW-1:2], 2'b00};
                o_mem_wdata = w_wdata;
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = r_err;
                o_rsp_rdata = r_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit on the consumer side of the decoder's memory controls (rw, whb, su).
- Takes one load/store request from the core and drives a word-wide data-memory port with byte enables.
- Returns aligned, sign- or zero-extended load data, or a completion/error for stores.
- Sits between the execute stage (ALU address, rs2 data) and the data memory; the core stalls while `req_ready` = 0.

Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles in REQ+WAIT before an error response (used only with `LSU_TIMEOUT_EN`).
- `AW`, 32: address width.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  core requests a memory access
- `req_ready`  out  1  unit idle, can accept a request
- `rw`  in  1  1 = load, 0 = store (same encoding as decoder)
- `whb`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `su`  in  1  1 = sign-extend load, 0 = zero-extend
- `addr`  in  AW  byte address
- `wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_err`  out  1  qualifies `rsp_valid`: misaligned/illegal/timeout
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write enable
- `mem_be`  out  4  byte lane enables
- `mem_addr`  out  AW  word address, {addr[AW-1:2],2'b00}
- `mem_wdata`  out  32  lane-replicated store data
- `mem_gnt`  in  1  memory accepted request this cycle
- `mem_rvalid`  in  1  read data valid this cycle
- `mem_rdata`  in  32  read word

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs 0, except `req_ready` = 1.
  - Latched request registers cleared.
  - Reset mid-transaction abandons the access; no response is produced.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE (`req_ready` = 1):
  - On `req_valid`, latch rw, whb, su, addr, wdata.
  - Misaligned or illegal request → RESP with error flag set; no memory access.
  - Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; whb=11.
  - Otherwise → REQ.
- REQ:
  - `mem_req` = 1; `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` held stable until `mem_gnt`.
  - On `mem_gnt`: store → RESP; load → WAIT.
  - `mem_req` deasserts the cycle after the grant.
- WAIT:
  - On `mem_rvalid`, extract the lane, extend it, register the result → RESP.
  - `mem_rvalid` in any other state is ignored; `mem_gnt` outside REQ is ignored.
- RESP:
  - `rsp_valid` = 1 for exactly one cycle with `rsp_err`/`rsp_rdata`, then → IDLE.
  - `rsp_err` and `rsp_rdata` are 0 whenever `rsp_valid` = 0.
- `req_ready` = 0 in every state except IDLE. Back-to-back requests are separated by at least one IDLE cycle.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - `mem_be` = 0 when `mem_req` = 0.
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - byte = mem_rdata >> (8*addr[1:0]), bits [7:0].
  - half = mem_rdata >> (16*addr[1]), bits [15:0].
  - `su`=1 replicates the MSB of the extracted field; `su`=0 zero-fills.
- Minimum latency, acceptance edge = cycle 0 (grant and `mem_rvalid` each in the first cycle possible):
  - store: `mem_req` at cycle 1, `rsp_valid` at cycle 2.
  - load: `rsp_valid` at cycle 3.
  - misaligned: `rsp_valid` at cycle 1.

Optional Feature:
- Macro: `LSU_TIMEOUT_EN`.
- Defined:
  - An 8+ bit counter clears on entering REQ and counts each cycle in REQ/WAIT.
  - When it reaches `TIMEOUT_CYCLES` without grant/rvalid: drop `mem_req`, go to RESP with `rsp_err` = 1.
- Undefined: no counter; the unit waits indefinitely in REQ/WAIT.

Decomposition:
- Package `lsu_pkg`:
  - whb encodings WHB_BYTE=2'b00, WHB_HALF=2'b01, WHB_WORD=2'b10.
  - FSM state encoding.
  - Default `TIMEOUT_CYCLES`.
- Sub-module `lsu_load_align` (combinational): mem_rdata, addr[1:0], whb, su → extended 32-bit load data.

Test Plan:
- LB su=1, addr=0x1003, mem_rdata=0x80_12_34_56, gnt and rvalid immediate → `mem_be`=4'b1000, `mem_addr`=0x1000, `rsp_rdata`=0xFFFFFF80 at cycle 3; LBU same → 0x00000080.
- SH addr=0x2002, wdata=0xDEADBEEF, gnt delayed 3 cycles → `mem_be`=4'b1100 and `mem_wdata`=0xBEEFBEEF held stable for 4 cycles; `rsp_valid` 1 cycle after grant, `rsp_err`=0.
- LW addr=0x3001 → no `mem_req` ever; `rsp_valid`=1 with `rsp_err`=1 and `rsp_rdata`=0 at cycle 1; whb=11 on an aligned address → same.
- LH su=1 addr=0x4002, mem_rdata=0x8001_7FFF → 0xFFFF8001; stray `mem_rvalid` while IDLE → no `rsp_valid`.
- `rst` asserted during WAIT, late `mem_rvalid` next cycle → no response, `req_ready`=1, all memory outputs 0.
- `LSU_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=4, `mem_gnt` held 0 → `mem_req` drops and `rsp_err`=1 after 4 cycles in REQ; without the macro the request stays pending for 100+ cycles.
